// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
// SPI_REG_AUTOINC_EN selects address auto-increment in spi_reg_ctrl.
package spi_reg_pkg;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  localparam logic [7:0] TX_IDLE_BYTE = 8'hA5;
  localparam logic [2:0] STATUS_ADDR  = 3'd7;
  localparam int         NUM_REGS     = 7;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 2;
  localparam int CMD_ADDR_LSB = 0;

  // Address space is exactly 3 bits, so the natural overflow gives the 7->0 wrap.
  function automatic logic [2:0] nextAddr(input logic [2:0] addr);
    return addr + 3'd1;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI slave PHY (master side) and the register controller (slave side).
interface spi_reg_ctrl_if;

  logic       cs_n;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;

  modport master (output cs_n, output rx_valid, output rx_byte, input tx_byte);
  modport slave  (input cs_n, input rx_valid, input rx_byte, output tx_byte);

endinterface

// File: rtl/spi_reg_file.sv
// Seven 8-bit configuration registers with one synchronous write port and a
// combinational read mux that maps the status input at the top address.
module spi_reg_file
  import spi_reg_pkg::*;
(
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [2:0]              wrAddr_i,
  input  logic [7:0]              wrData_i,
  input  logic [2:0]              rdAddr_i,
  output logic [7:0]              rdData_o,
  input  logic [7:0]              status_i,
  output logic [8*NUM_REGS-1:0]   regs_o
);

  logic [7:0] regs_q [NUM_REGS];

  // Address 7 has no storage behind it, so a write there matches no entry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_i && wrAddr_i == 3'(i)) regs_q[i] <= wrData_i;
      end
    end
  end

  always_comb begin
    rdData_o = status_i;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rdAddr_i == 3'(i)) rdData_o = regs_q[i];
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[8*i +: 8] = regs_q[i];
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command/data framer in front of spi_reg_file. Define SPI_REG_AUTOINC_EN
// to step the address after every data byte; otherwise it stays at the command address.
module spi_reg_ctrl
  import spi_reg_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  rst_n,
  spi_reg_ctrl_if.slave         spi,
  input  logic [7:0]            status_in,
  output logic [8*NUM_REGS-1:0] cfg_regs,
  output logic                  wr_strobe,
  output logic [2:0]            wr_addr
);

  state_e     state_q, state_d;
  logic [2:0] addr_q, addr_d, stepAddr, rdAddr, wrAddr_q;
  logic [7:0] txByte_q, txByte_d, rdData;
  logic       wrStrobe_q, armed_q, we, byteIn;

`ifdef SPI_REG_AUTOINC_EN
  assign stepAddr = nextAddr(addr_q);
`else
  assign stepAddr = addr_q;
`endif

  assign byteIn = !spi.cs_n && spi.rx_valid;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // armed_q blocks a frame from starting until cs_n has been seen high since reset.
  always_comb begin
    state_d = state_q;
    if (spi.cs_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (armed_q) state_d = CMD;
        CMD:     if (spi.rx_valid) state_d = spi.rx_byte[CMD_RW_BIT] ? RDATA : WDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rdAddr = stepAddr;
    if (state_q == CMD) rdAddr = spi.rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
  end

  always_comb begin
    addr_d   = addr_q;
    txByte_d = txByte_q;
    we       = 1'b0;
    if (state_d == IDLE || state_d == CMD) begin
      txByte_d = TX_IDLE_BYTE;
    end else if (byteIn) begin
      case (state_q)
        CMD: begin
          addr_d = spi.rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
          if (spi.rx_byte[CMD_RW_BIT]) txByte_d = rdData;
        end
        WDATA: begin
          we     = (addr_q != STATUS_ADDR);
          addr_d = stepAddr;
        end
        RDATA: begin
          addr_d   = stepAddr;
          txByte_d = rdData;
        end
        default: addr_d = addr_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      txByte_q   <= TX_IDLE_BYTE;
      wrStrobe_q <= 1'b0;
      wrAddr_q   <= '0;
      armed_q    <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      txByte_q   <= txByte_d;
      wrStrobe_q <= we;
      if (we) wrAddr_q <= addr_q;
      if (spi.cs_n) armed_q <= 1'b1;
    end
  end

  spi_reg_file u_regFile (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .we_i     (we),
    .wrAddr_i (addr_q),
    .wrData_i (spi.rx_byte),
    .rdAddr_i (rdAddr),
    .rdData_o (rdData),
    .status_i (status_in),
    .regs_o   (cfg_regs)
  );

  assign spi.tx_byte = txByte_q;
  assign wr_strobe   = wrStrobe_q;
  assign wr_addr     = wrAddr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl; expectations follow SPI_REG_AUTOINC_EN when defined.
module tb_spi_reg_ctrl;

  logic        sys_clk;
  logic        rst_n;
  logic [7:0]  status_in;
  logic [55:0] cfg_regs;
  logic        wr_strobe;
  logic [2:0]  wr_addr;

  int compareCount  = 0;
  int mismatchCount = 0;

  spi_reg_ctrl_if spiBus ();

  spi_reg_ctrl dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .spi       (spiBus.slave),
    .status_in (status_in),
    .cfg_regs  (cfg_regs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One rx_valid pulse; returns just after the edge that consumed it.
  task automatic applyStimulus(input logic [7:0] b);
    spiBus.rx_valid = 1'b1;
    spiBus.rx_byte  = b;
    tick();
    spiBus.rx_valid = 1'b0;
  endtask

  task automatic frameStart();
    spiBus.cs_n = 1'b0;
    tick();
  endtask

  task automatic frameEnd();
    spiBus.cs_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst_n           = 1'b0;
    spiBus.cs_n     = 1'b1;
    spiBus.rx_valid = 1'b0;
    spiBus.rx_byte  = 8'h00;
    status_in       = 8'h00;
    tick();
    tick();
    checkOutput("rst_cfg",    64'(cfg_regs),       64'h0);
    checkOutput("rst_tx",     64'(spiBus.tx_byte), 64'hA5);
    checkOutput("rst_strobe", 64'(wr_strobe),      64'h0);
    checkOutput("rst_waddr",  64'(wr_addr),        64'h0);
    rst_n = 1'b1;
    tick();
    tick();

    $display("[TB] write reg2 = 0x3C");
    frameStart();
    applyStimulus(8'h02);
    checkOutput("wr_cmd_tx",     64'(spiBus.tx_byte), 64'hA5);
    checkOutput("wr_cmd_strobe", 64'(wr_strobe),      64'h0);
    tick();
    applyStimulus(8'h3C);
    checkOutput("wr_strobe", 64'(wr_strobe), 64'h1);
    checkOutput("wr_addr",   64'(wr_addr),   64'h2);
    checkOutput("wr_cfg",    64'(cfg_regs),  64'h0000_0000_3C00_00);
    tick();
    checkOutput("wr_strobe_single", 64'(wr_strobe), 64'h0);
    frameEnd();

    $display("[TB] read from reg2");
    frameStart();
    applyStimulus(8'h82);
    checkOutput("rd_first", 64'(spiBus.tx_byte), 64'h3C);
    tick();
    applyStimulus(8'h00);
`ifdef SPI_REG_AUTOINC_EN
    checkOutput("rd_second", 64'(spiBus.tx_byte), 64'h00);
`else
    checkOutput("rd_second", 64'(spiBus.tx_byte), 64'h3C);
`endif
    checkOutput("rd_no_strobe", 64'(wr_strobe), 64'h0);
    checkOutput("rd_cfg_kept",  64'(cfg_regs),  64'h0000_0000_3C00_00);
    frameEnd();
    checkOutput("rd_end_tx", 64'(spiBus.tx_byte), 64'hA5);

    $display("[TB] write burst from reg6");
    frameStart();
    applyStimulus(8'h06);
    tick();
    applyStimulus(8'h11);
    checkOutput("wrap_s1",   64'(wr_strobe), 64'h1);
    checkOutput("wrap_a1",   64'(wr_addr),   64'h6);
    tick();
    applyStimulus(8'h22);
`ifdef SPI_REG_AUTOINC_EN
    checkOutput("wrap_s2", 64'(wr_strobe), 64'h0);
`else
    checkOutput("wrap_s2", 64'(wr_strobe), 64'h1);
    checkOutput("wrap_a2", 64'(wr_addr),   64'h6);
`endif
    tick();
    applyStimulus(8'h33);
    checkOutput("wrap_s3", 64'(wr_strobe), 64'h1);
`ifdef SPI_REG_AUTOINC_EN
    checkOutput("wrap_a3",  64'(wr_addr),  64'h0);
    checkOutput("wrap_cfg", 64'(cfg_regs), 64'h1100_0000_3C00_33);
`else
    checkOutput("wrap_a3",  64'(wr_addr),  64'h6);
    checkOutput("wrap_cfg", 64'(cfg_regs), 64'h3300_0000_3C00_00);
`endif
    frameEnd();

    $display("[TB] status read and address-7 write");
    status_in = 8'h5A;
    frameStart();
    applyStimulus(8'h87);
    checkOutput("stat_tx", 64'(spiBus.tx_byte), 64'h5A);
    status_in = 8'h66;
    tick();
    applyStimulus(8'h00);
`ifdef SPI_REG_AUTOINC_EN
    checkOutput("stat_next", 64'(spiBus.tx_byte), 64'h33);
`else
    checkOutput("stat_next", 64'(spiBus.tx_byte), 64'h66);
`endif
    frameEnd();
    frameStart();
    applyStimulus(8'h07);
    tick();
    applyStimulus(8'h99);
    checkOutput("stat_wr_strobe", 64'(wr_strobe), 64'h0);
`ifdef SPI_REG_AUTOINC_EN
    checkOutput("stat_wr_cfg", 64'(cfg_regs), 64'h1100_0000_3C00_33);
`else
    checkOutput("stat_wr_cfg", 64'(cfg_regs), 64'h3300_0000_3C00_00);
`endif
    frameEnd();

    $display("[TB] abort between command and data");
    frameStart();
    applyStimulus(8'h01);
    tick();
    spiBus.cs_n = 1'b1;
    tick();
    checkOutput("abort1_tx", 64'(spiBus.tx_byte), 64'hA5);
    applyStimulus(8'h77);
    checkOutput("abort1_strobe", 64'(wr_strobe), 64'h0);
    tick();

    $display("[TB] abort together with data byte");
    frameStart();
    applyStimulus(8'h01);
    tick();
    spiBus.cs_n = 1'b1;
    applyStimulus(8'h55);
    checkOutput("abort2_strobe", 64'(wr_strobe),      64'h0);
    checkOutput("abort2_tx",     64'(spiBus.tx_byte), 64'hA5);
`ifdef SPI_REG_AUTOINC_EN
    checkOutput("abort2_cfg", 64'(cfg_regs), 64'h1100_0000_3C00_33);
`else
    checkOutput("abort2_cfg", 64'(cfg_regs), 64'h3300_0000_3C00_00);
`endif
    tick();
    frameStart();
    applyStimulus(8'h82);
    checkOutput("abort2_newcmd_tx",     64'(spiBus.tx_byte), 64'h3C);
    checkOutput("abort2_newcmd_strobe", 64'(wr_strobe),      64'h0);
    frameEnd();

    $display("[TB] reset in the middle of a read");
    frameStart();
    applyStimulus(8'h05);
    tick();
    applyStimulus(8'h5E);
    checkOutput("rst_pre_waddr", 64'(wr_addr), 64'h5);
    frameEnd();
    frameStart();
    applyStimulus(8'h85);
    checkOutput("rst_pre_tx", 64'(spiBus.tx_byte), 64'h5E);
    tick();
    rst_n = 1'b0;
    #2;
    checkOutput("rstmid_cfg",    64'(cfg_regs),       64'h0);
    checkOutput("rstmid_tx",     64'(spiBus.tx_byte), 64'hA5);
    checkOutput("rstmid_strobe", 64'(wr_strobe),      64'h0);
    checkOutput("rstmid_waddr",  64'(wr_addr),        64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(8'h05);
    checkOutput("rstpost_cmd_tx",     64'(spiBus.tx_byte), 64'hA5);
    checkOutput("rstpost_cmd_strobe", 64'(wr_strobe),      64'h0);
    tick();
    applyStimulus(8'hEE);
    checkOutput("rstpost_data_strobe", 64'(wr_strobe), 64'h0);
    checkOutput("rstpost_data_cfg",    64'(cfg_regs),  64'h0);
    frameEnd();
    frameStart();
    applyStimulus(8'h01);
    tick();
    applyStimulus(8'h42);
    checkOutput("rstnew_strobe", 64'(wr_strobe), 64'h1);
    checkOutput("rstnew_waddr",  64'(wr_addr),   64'h1);
    checkOutput("rstnew_cfg",    64'(cfg_regs),  64'h0000_0000_0042_00);
    frameEnd();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have port sys_clk, input, 1: sole clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-003 SHALL have port cs_n, input, 1: SPI chip select (already synchronised to sys_clk), low = frame active.
REQ-004 SHALL have port rx_valid, input, 1: one-sys_clk pulse per received SPI byte.
REQ-005 SHALL have port rx_byte, input, 8: received byte, valid while rx_valid=1.
REQ-006 SHALL have port tx_byte, output, 8: byte presented to the SPI slave for the next transfer.
REQ-007 SHALL have port status_in, input, 8: read-only status, mapped at address 7.
REQ-008 SHALL have port cfg_regs, output, 56: registers 0..6 concatenated, reg0 in bits 7:0.
REQ-009 SHALL have port wr_strobe, output, 1: one-cycle pulse on each register write.
REQ-010 SHALL have port wr_addr, output, 3: address of the write flagged by wr_strobe.

Function
REQ-011 SHALL implement states IDLE, CMD, WDATA, RDATA.
REQ-012 SHALL move IDLE->CMD on a sys_clk where cs_n=0.
REQ-013 SHALL treat the first rx_valid in CMD as the command byte: bit7 = 1 read / 0 write, bits2:0 = start address, bits6:3 ignored.
REQ-014 SHALL move CMD->WDATA on a write command and CMD->RDATA on a read command.
REQ-015 SHALL, in WDATA, on each rx_valid write rx_byte to the current address and pulse wr_strobe with wr_addr in the following cycle.
REQ-016 SHALL ignore writes to address 7 (no register change, no wr_strobe).
REQ-017 SHALL, on a read command, load tx_byte with the content of the start address one cycle after the command rx_valid.
REQ-018 SHALL, in RDATA, reload tx_byte from the next address one cycle after each rx_valid.
REQ-019 SHALL read address 7 as status_in, sampled when tx_byte is loaded.
REQ-020 SHALL return to IDLE within one cycle of cs_n=1 from any state, discarding a partial command; registers already written SHALL be kept.
REQ-021 SHALL let cs_n=1 take priority over a simultaneous rx_valid (byte dropped).
REQ-022 SHALL set tx_byte to 8'hA5 in IDLE and CMD, so the byte clocked out during the command byte is a known marker.
REQ-023 SHALL wrap the address 7->0.

Reset
REQ-024 SHALL, while rst_n=0, force: state IDLE, cfg_regs 0, tx_byte 8'hA5, wr_strobe 0, wr_addr 0, address counter 0.
REQ-025 SHALL abort any frame in progress when reset asserts mid-frame, and SHALL require a fresh cs_n high->low after release.

Configuration
REQ-026 SHALL use macro SPI_REG_AUTOINC_EN.
REQ-027 SHALL, when SPI_REG_AUTOINC_EN is defined, increment the address after every data byte in WDATA/RDATA, with wrap per REQ-023.
REQ-028 SHALL, when SPI_REG_AUTOINC_EN is undefined, hold the address fixed at the command address for the entire frame.

Structure
REQ-029 SHALL place state encoding, TX_IDLE_BYTE (8'hA5), STATUS_ADDR (3'd7), NUM_REGS (7) and the command bit positions in shared package spi_reg_pkg.
REQ-030 SHALL use one sub-module spi_reg_file: 7x8 storage, synchronous write port, combinational read mux including status_in.

Verification
REQ-031 Bench SHALL cover write: cs_n low, bytes 0x02, 0x3C -> reg2=0x3C, single wr_strobe, wr_addr=2.
REQ-032 Bench SHALL cover read: after REQ-031, frame 0x82 then dummy byte -> tx_byte=0x3C one cycle after the command rx_valid; with AUTOINC, the next byte returns reg3.
REQ-033 Bench SHALL cover wrap: with AUTOINC, write 0x06 then 0x11, 0x22, 0x33 -> reg6=0x11, address-7 write ignored, reg0=0x33.
REQ-034 Bench SHALL cover status: status_in=0x5A, frame 0x87 -> tx_byte=0x5A; a write to address 7 gives no wr_strobe.
REQ-035 Bench SHALL cover abort: cs_n rises between the command and the data byte, or simultaneously with the data rx_valid -> no write, state IDLE, tx_byte=0xA5.
REQ-036 Bench SHALL cover reset: rst_n low mid-RDATA -> all outputs at REQ-024 values immediately, with no write after release until a new frame.
